// File: rtl/uart_tx_stream.sv
// uart_tx_stream: valid/ready-fed UART transmitter with a one-word holding register,
// runtime parity/stop selection and an internal bit-period prescaler.
module uart_tx_stream #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  output logic                      Data_Ready,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      stop_two,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d, shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d, pm1_q, pm1_d;
  logic [IW-1:0] idx_q, idx_d;
  logic hold_full_q, hold_full_d, par_en_q, par_en_d, stop2_q, stop2_d;
  logic par_bit_q, par_bit_d, tx_q, tx_d, busy_q, busy_d;
  logic hs, last, frame_end, launch;
  always_comb begin
    hs = Data_Valid & ~hold_full_q;
    last = cnt_q == '0;
    frame_end = last && (state_q == STOP2 || (state_q == STOP1 && !stop2_q));
    launch = hold_full_q && (state_q == IDLE || frame_end);
    hold_full_d = hs | (hold_full_q & ~launch);
    hold_data_d = hs ? P_DATA : hold_data_q;
    // frame configuration is captured only at launch so mid-frame input changes are ignored
    par_en_d = launch ? parity_enable : par_en_q;
    stop2_d = launch ? stop_two : stop2_q;
    par_bit_d = launch ? (^hold_data_q) ^ parity_type : par_bit_q;
    pm1_d = launch ? (prescale == '0 ? '0 : prescale - PRESCALE_WIDTH'(1)) : pm1_q;
    state_d = state_q;
    idx_d = idx_q;
    shift_d = launch ? hold_data_q : shift_q;
    if (launch) state_d = START;
    else if (frame_end) state_d = IDLE;
    else if (last)
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d = '0;
        end
        DATA:
          if (idx_q == IW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP1;
          else begin
            idx_d = idx_q + IW'(1);
            shift_d = shift_q >> 1;
          end
        PARITY: state_d = STOP1;
        STOP1: state_d = STOP2;
        default: ;
      endcase
    cnt_d = state_d == IDLE ? '0 : (launch | last) ? pm1_d : cnt_q - PRESCALE_WIDTH'(1);
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_bit_q : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q <= '0;
      cnt_q <= '0;
      pm1_q <= '0;
      idx_q <= '0;
      par_en_q <= 1'b0;
      stop2_q <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      pm1_q <= pm1_d;
      idx_q <= idx_d;
      par_en_q <= par_en_d;
      stop2_q <= stop2_d;
      par_bit_q <= par_bit_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
  end
  assign Data_Ready = ~hold_full_q;
  assign TX_OUT = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed frames; expected line patterns are queued at stimulus time
// and a monitor checks every line cycle of each frame as it appears.
module tb_uart_tx_stream;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] data = '0;
  logic valid = 1'b0, use5 = 1'b0, par_en = 1'b0, par_ty = 1'b0, st2 = 1'b0;
  logic [15:0] presc = 16'd1;
  logic rdy8, tx8, bsy8, rdy5, tx5, bsy5, line, rdy, bsy;
  logic bsy_prev = 1'b0;
  int cyc = 0, busy_cyc = 0, rises = 0, n_chk = 0, n_pass = 0;

  uart_tx_stream #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(data), .Data_Valid(valid & ~use5), .Data_Ready(rdy8),
    .parity_enable(par_en), .parity_type(par_ty), .stop_two(st2), .prescale(presc),
    .TX_OUT(tx8), .busy(bsy8));
  uart_tx_stream #(.DATA_WIDTH(5), .PRESCALE_WIDTH(16)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(data[4:0]), .Data_Valid(valid & use5), .Data_Ready(rdy5),
    .parity_enable(par_en), .parity_type(par_ty), .stop_two(st2), .prescale(presc),
    .TX_OUT(tx5), .busy(bsy5));

  assign line = use5 ? tx5 : tx8;
  assign rdy = use5 ? rdy5 : rdy8;
  assign bsy = use5 ? bsy5 : bsy8;

  typedef struct {logic [15:0] bits; int n; int p;} frame_t;
  frame_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bsy && !bsy_prev) rises <= rises + 1;
    if (bsy) busy_cyc <= busy_cyc + 1;
    bsy_prev <= bsy;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int n, input int p);
    frame_t f;
    f.bits = bits;
    f.n = n;
    f.p = p;
    exp_q.push_back(f);
  endtask

  task automatic send(input logic [7:0] d, output int hc);
    int w = 0;
    valid = 1'b1;
    data = d;
    while (!rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rdy) timeout("send_ready");
    hc = cyc;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic finish_frames(input string nm, input int exp_busy, input int exp_rises,
                               input int b0, input int r0);
    int w = 0;
    while ((bsy || !rdy) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (bsy || !rdy) timeout({nm, "_idle"});
    chk({nm, "_busy_cycles"}, busy_cyc - b0, exp_busy);
    chk({nm, "_busy_rises"}, rises - r0, exp_rises);
  endtask

  initial begin : monitor
    frame_t f;
    int got, nf, w;
    nf = 0;
    forever begin
      @(negedge clk);
      if (!rst && line === 1'b0) begin
        chk("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() == 0) begin
          w = 0;
          while (line === 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
          end
        end else begin
          f = exp_q.pop_front();
          for (int b = 0; b < f.n; b++) begin
            got = int'(f.bits[b]);
            for (int c = 0; c < f.p; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (line !== f.bits[b]) got = int'(line);
            end
            chk($sformatf("frame%0d_bit%0d", nf, b), got, int'(f.bits[b]));
          end
          nf++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int b0, r0, h1, h2, h3;
    repeat (3) @(negedge clk);
    chk("reset_tx8", int'(tx8), 1);
    chk("reset_tx5", int'(tx5), 1);
    chk("reset_busy", int'(bsy8), 0);
    chk("reset_ready", int'(rdy8), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1, prescale 4, 0xA5
    presc = 16'd4;
    expect_frame(16'({1'b1, 8'hA5, 1'b0}), 10, 4);
    b0 = busy_cyc; r0 = rises;
    send(8'hA5, h1);
    chk("a5_ready_drop", int'(rdy), 0);
    chk("a5_busy_before", int'(bsy), 0);
    @(negedge clk);
    chk("a5_ready_back", int'(rdy), 1);
    chk("a5_busy_rise", int'(bsy), 1);
    chk("a5_start_low", int'(line), 0);
    finish_frames("a5", 40, 1, b0, r0);

    // even then odd parity, prescale 2, 0x03
    presc = 16'd2; par_en = 1'b1; par_ty = 1'b0;
    expect_frame(16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 2);
    b0 = busy_cyc; r0 = rises;
    send(8'h03, h1);
    finish_frames("even", 22, 1, b0, r0);
    par_ty = 1'b1;
    expect_frame(16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 2);
    b0 = busy_cyc; r0 = rises;
    send(8'h03, h1);
    finish_frames("odd", 22, 1, b0, r0);

    // two stop bits, prescale 3
    par_en = 1'b0; par_ty = 1'b0; st2 = 1'b1; presc = 16'd3;
    expect_frame(16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, 3);
    b0 = busy_cyc; r0 = rises;
    send(8'h5A, h1);
    finish_frames("stop2", 33, 1, b0, r0);

    // back-to-back, prescale 1, valid held across three words
    st2 = 1'b0; presc = 16'd1;
    expect_frame(16'({1'b1, 8'h11, 1'b0}), 10, 1);
    expect_frame(16'({1'b1, 8'h22, 1'b0}), 10, 1);
    expect_frame(16'({1'b1, 8'h33, 1'b0}), 10, 1);
    b0 = busy_cyc; r0 = rises;
    send(8'h11, h1);
    send(8'h22, h2);
    send(8'h33, h3);
    chk("b2b_second_accept", h2 - h1, 2);
    chk("b2b_third_accept", h3 - h1, 12);
    finish_frames("b2b", 30, 1, b0, r0);

    // reset during DATA of 0xFF with a word pending
    presc = 16'd2;
    expect_frame(16'({1'b1, 1'b1, 1'b0}), 3, 2);
    send(8'hFF, h1);
    send(8'h00, h2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx_high", int'(line), 1);
    chk("rst_busy_low", int'(bsy), 0);
    chk("rst_ready_high", int'(rdy), 1);
    rst = 1'b0;
    b0 = busy_cyc; r0 = rises;
    repeat (20) @(negedge clk);
    chk("rst_no_restart", busy_cyc - b0, 0);
    chk("rst_line_idle", int'(line), 1);

    // 5-bit build, prescale 0 behaves as 1; change mid-frame is ignored
    use5 = 1'b1; presc = 16'd0;
    expect_frame(16'({1'b1, 5'h15, 1'b0}), 7, 1);
    b0 = busy_cyc; r0 = rises;
    send(8'h15, h1);
    @(negedge clk);
    presc = 16'd3;
    finish_frames("w5", 7, 1, b0, r0);
    use5 = 1'b0; presc = 16'd1;

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter, successor to the fixed-frame TX path. Takes parallel words through a valid/ready handshake into a one-entry holding register, so the next word can be accepted while the current frame is on the line. Runtime-selectable parity, 1 or 2 stop bits, and an internal bit-period prescaler. Sits between the system-side data source and the serial TX pin, all in the core clock domain.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9
- PRESCALE_WIDTH, 16: width of the prescale input
- CLK  in  1  core clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- P_DATA  in  DATA_WIDTH  word to transmit, LSB sent first
- Data_Valid  in  1  P_DATA is valid; transfer when Data_Valid & Data_Ready at a CLK edge
- Data_Ready  out  1  holding register empty (= ~hold_full)
- parity_enable  in  1  1 = append a parity bit
- parity_type  in  1  0 = even, 1 = odd
- stop_two  in  1  1 = two stop bits, 0 = one
- prescale  in  PRESCALE_WIDTH  CLK cycles per bit; 0 is treated as 1
- TX_OUT  out  1  serial line, idle high, registered
- busy  out  1  high while a frame is on the line (state != IDLE), registered

## Operation
- Holding register (hold_data, hold_full):
  - It loads on a handshake.
  - It empties when the FSM launches a frame from it.
  - If a launch and a new handshake fall in the same cycle, the new word is stored and hold_full stays 1.
- The frame configuration (parity_enable, parity_type, stop_two, prescale) is latched at launch and held for the whole frame. Mid-frame input changes have no effect.
- Parity bit = XOR of the data word, inverted when parity_type = 1.
- FSM states and outputs:
  - IDLE: TX_OUT = 1.
  - START: TX_OUT = 0.
  - DATA: shifts out DATA_WIDTH bits, LSB first.
  - PARITY: sends the parity bit (only if parity_enable is latched).
  - STOP1: TX_OUT = 1.
  - STOP2: TX_OUT = 1 (only if stop_two is latched).
- FSM transitions:
  - IDLE -> START when hold_full = 1.
  - Each state lasts exactly P cycles, where P = max(prescale, 1), timed by a bit counter that reloads on every state change.
  - DATA uses a bit index 0..DATA_WIDTH-1 and leaves after the last bit.
  - At the end of the last stop bit: go to START if hold_full = 1 (back-to-back, no idle bit), else go to IDLE.
- Reset (RST = 1 at an edge):
  - Register values: TX_OUT = 1, busy = 0, hold_full = 0 (so Data_Ready = 1), state = IDLE, counters = 0.
  - A handshake in a reset cycle is discarded.
  - Reset mid-frame aborts the frame immediately. The line returns high on the next cycle.

## Timing
- Latency: handshake at edge N with FSM idle -> TX_OUT = 0 and busy = 1 from edge N+1.
- Frame length = P × (1 + DATA_WIDTH + parity_enable + 1 + stop_two) cycles.
- Data_Ready:
  - Drops the cycle after a handshake that fills the register.
  - When launching from IDLE, the register empties at edge N+1, so Data_Ready is high again from N+1.
  - A second word therefore can be taken one cycle after the first.
- Back-to-back frames: the start bit of frame k+1 begins on the cycle immediately after the last stop-bit cycle of frame k. busy stays 1 continuously.
- busy falls on the cycle after the last stop-bit cycle when no word is pending.

## Test plan
- **8N1, prescale = 4, P_DATA = 0xA5, single handshake:**
  - TX_OUT = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 with 4 cycles each, then 1 for 4 cycles.
  - busy high for exactly 40 cycles.
  - Data_Ready returns to 1 one cycle after the handshake.
- **Parity, prescale = 2, P_DATA = 0x03:**
  - parity_enable = 1, parity_type = 0: parity bit = 0, frame = 22 cycles.
  - Repeat with parity_type = 1: parity bit = 1.
- **stop_two = 1, prescale = 3, 8 bits, no parity:**
  - TX_OUT high for 6 cycles after the last data bit.
  - Frame = 33 cycles.
- **Three words 0x11, 0x22, 0x33 with Data_Valid held high, prescale = 1:**
  - 0x11 is accepted at once, 0x22 one cycle later; Data_Ready then stays 0 until 0x11's frame launches 0x22.
  - 30 contiguous line bits, no idle gap, busy never drops.
  - The third word waits with Data_Valid held.
- **RST asserted mid-DATA of an 0xFF frame with a word pending:**
  - Next cycle: TX_OUT = 1, busy = 0, Data_Ready = 1.
  - No further frame starts until a new handshake.
- **prescale = 0, DATA_WIDTH = 5 build, P_DATA = 0x15:**
  - Behaves as prescale = 1: 7-cycle frame 0,1,0,1,0,1,1.
  - A prescale change mid-frame does not alter bit lengths.
